// File: rtl/mc_regbank.sv
// mc_regbank: bank of N CPLD macrocell storage elements (D / T / bypass /
// hold, optional output inversion) configured through a serial shadow chain
// that is copied into the active configuration on cfg_update.

// One macrocell channel: storage bit with per-channel async reset/set,
// mode-dependent next-state logic and the output mux/inverter.
module mc_cell (
  input  logic       gclk,
  input  logic       gclr_n,
  input  logic       d,
  input  logic       ce,
  input  logic       ar,
  input  logic       as,
  input  logic [2:0] cfg,
  output logic       q
);
  localparam logic [1:0] MODE_D    = 2'b00;
  localparam logic [1:0] MODE_T    = 2'b01;
  localparam logic [1:0] MODE_BYP  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic st_q, st_d;
  logic arst, aset;

  // Global clear and the channel reset both clear the bit and win over set.
  // Set is qualified by the absence of any reset, so releasing ar while as
  // is still high produces a rising aset and the bit goes to 1 at once.
  assign arst = ~gclr_n | ar;
  assign aset = as & ~arst;

  // Next-state per mode; bypass keeps loading like D so a later return to D
  // starts from a current value.
  always_comb begin
    st_d = st_q;
    case (cfg[1:0])
      MODE_D, MODE_BYP: if (ce)      st_d = d;
      MODE_T:           if (ce && d) st_d = ~st_q;
      MODE_HOLD:        st_d = st_q;
      default:          st_d = st_q;
    endcase
  end

  // Storage bit: async clear/set are level-like (re-evaluated at every clock
  // edge while held), otherwise a normal synchronous update.
  always_ff @(posedge gclk or posedge arst or posedge aset) begin
    if (arst)      st_q <= 1'b0;
    else if (aset) st_q <= 1'b1;
    else           st_q <= st_d;
  end

  // Bypass routes d straight through, so async controls never reach q there.
  always_comb begin
    q = ((cfg[1:0] == MODE_BYP) ? d : st_q) ^ cfg[2];
  end
endmodule

module mc_regbank #(
  parameter int N = 16
) (
  input  logic         gclk,
  input  logic         gclr_n,
  input  logic [N-1:0] d,
  input  logic [N-1:0] ce,
  input  logic [N-1:0] ar,
  input  logic [N-1:0] as,
  input  logic         cfg_shift,
  input  logic         cfg_sdi,
  input  logic         cfg_update,
  output logic         cfg_sdo,
  output logic [N-1:0] q,
  output logic [N-1:0] qn
);
  localparam int CW = 3 * N;

  logic [CW-1:0] sr_q, sr_d;
  logic [CW-1:0] cfg_q, cfg_d;

  // Shadow chain shifts toward bit 0; update captures the pre-shift chain,
  // so a combined shift+update edge latches the old contents.
  always_comb begin
    sr_d  = sr_q;
    cfg_d = cfg_q;
    if (cfg_update) cfg_d = sr_q;
    if (cfg_shift)  sr_d  = {cfg_sdi, sr_q[CW-1:1]};
  end

  // Chain and active config registers; global clear drops any partial shift.
  always_ff @(posedge gclk or negedge gclr_n) begin
    if (!gclr_n) begin
      sr_q  <= '0;
      cfg_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cfg_q <= cfg_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_cell
      mc_cell u_cell (
        .gclk   (gclk),
        .gclr_n (gclr_n),
        .d      (d[g]),
        .ce     (ce[g]),
        .ar     (ar[g]),
        .as     (as[g]),
        .cfg    (cfg_q[3*g +: 3]),
        .q      (q[g])
      );
    end
  endgenerate

  assign qn      = ~q;
  assign cfg_sdo = sr_q[0];
endmodule

// File: tb/tb_mc_regbank.sv
// Bench for mc_regbank: directed steps plus randomized traffic, checked
// against a behavioural model (per-channel state arrays and a bit queue for
// the configuration chain).
module tb_mc_regbank;
  localparam int N  = 4;
  localparam int CW = 3 * N;

  logic         gclk = 1'b0;
  logic         gclr_n;
  logic [N-1:0] d, ce, ar, as;
  logic         cfg_shift, cfg_sdi, cfg_update;
  logic         cfg_sdo;
  logic [N-1:0] q, qn;

  mc_regbank #(.N(N)) dut (
    .gclk(gclk), .gclr_n(gclr_n), .d(d), .ce(ce), .ar(ar), .as(as),
    .cfg_shift(cfg_shift), .cfg_sdi(cfg_sdi), .cfg_update(cfg_update),
    .cfg_sdo(cfg_sdo), .q(q), .qn(qn)
  );

  always #5 gclk = ~gclk;

  // reference model
  logic       m_st [N];
  logic [2:0] m_cfg[N];
  bit         chain[$];   // chain[0] is the bit presented on cfg_sdo

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [N-1:0] exp_q();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++)
      r[k] = ((m_cfg[k][1:0] == 2'd2) ? d[k] : m_st[k]) ^ m_cfg[k][2];
    return r;
  endfunction

  task automatic model_async();
    if (!gclr_n) begin
      for (int k = 0; k < N; k++) begin
        m_st[k]  = 1'b0;
        m_cfg[k] = 3'd0;
      end
      chain.delete();
      for (int i = 0; i < CW; i++) chain.push_back(1'b0);
    end else begin
      for (int k = 0; k < N; k++)
        if (ar[k])      m_st[k] = 1'b0;
        else if (as[k]) m_st[k] = 1'b1;
    end
  endtask

  task automatic tick();
    logic       nst [N];
    logic [2:0] ncfg[N];
    bit         live, do_shift, sdi_s;
    live     = gclr_n;
    do_shift = cfg_shift;
    sdi_s    = cfg_sdi;
    for (int k = 0; k < N; k++) begin
      nst[k]  = m_st[k];
      ncfg[k] = cfg_update ? {chain[3*k+2], chain[3*k+1], chain[3*k]} : m_cfg[k];
      if (!(ar[k] || as[k])) begin
        case (m_cfg[k][1:0])
          2'd0, 2'd2: if (ce[k]) nst[k] = d[k];
          2'd1:       if (ce[k] && d[k]) nst[k] = ~m_st[k];
          default:    nst[k] = m_st[k];
        endcase
      end
    end
    @(posedge gclk);
    if (live) begin
      for (int k = 0; k < N; k++) begin
        m_st[k]  = nst[k];
        m_cfg[k] = ncfg[k];
      end
      if (do_shift) begin
        void'(chain.pop_front());
        chain.push_back(sdi_s);
      end
    end
    #2;
    model_async();
  endtask

  task automatic check(input string tag);
    logic [N-1:0] e;
    e = exp_q();
    n_cmp++;
    assert (q === e) else begin
      n_bad++;
      $error("FAIL %s q got %h want %h", tag, q, e);
    end
    n_cmp++;
    assert (qn === ~e) else begin
      n_bad++;
      $error("FAIL %s qn got %h want %h", tag, qn, ~e);
    end
    n_cmp++;
    assert (cfg_sdo === chain[0]) else begin
      n_bad++;
      $error("FAIL %s cfg_sdo got %b want %b", tag, cfg_sdo, chain[0]);
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic shift_word(input logic [CW-1:0] w);
    cfg_shift = 1'b1;
    for (int i = 0; i < CW; i++) begin
      cfg_sdi = w[i];
      tick();
      check("shift");
    end
    cfg_shift = 1'b0;
    cfg_sdi   = 1'b0;
  endtask

  task automatic update();
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    check("update");
  endtask

  initial begin
    logic [CW-1:0] w, b;
    logic [N-1:0]  qv;
    logic          held;
    logic [4:0]    tseq;

    gclr_n = 1'b0; d = '0; ce = '0; ar = '0; as = '0;
    cfg_shift = 1'b0; cfg_sdi = 1'b0; cfg_update = 1'b0;
    #1 model_async();
    check("reset0");

    // reset held while everything else toggles
    for (int i = 0; i < 5; i++) begin
      d = N'($urandom); ce = N'($urandom);
      cfg_shift = 1'($urandom); cfg_sdi = 1'($urandom); cfg_update = 1'($urandom);
      tick();
      check("reset_hold");
      chk("reset_q", q, '0);
      chk("reset_sdo", {{(N-1){1'b0}}, cfg_sdo}, '0);
    end
    @(negedge gclk);
    gclr_n = 1'b1; d = '1; ce = '1;
    cfg_shift = 1'b0; cfg_sdi = 1'b0; cfg_update = 1'b0;
    tick();
    check("release");
    chk("release_q", q, '1);

    // chain ordering: first bit shifted lands on channel 0 mode bit 0
    d = '0;
    shift_word(CW'(1));
    chk("order_sdo", {{(N-1){1'b0}}, cfg_sdo}, N'(1));
    update();

    // T mode on channel 0
    d = N'(1); ce = N'(1);
    tseq = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("tmode");
      qv = q;
      chk("tmode_seq", N'(qv[0]), N'(tseq[4-i]));
    end
    ce = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("tmode_hold");
      qv = q;
      chk("tmode_hold_q0", N'(qv[0]), N'(1));
    end

    // simultaneous shift and update
    w = CW'({$urandom, $urandom});
    d = N'($urandom); ce = N'($urandom);
    shift_word(w);
    update();
    cfg_shift = 1'b1; cfg_update = 1'b1; cfg_sdi = 1'b1;
    tick();
    check("shift_upd");
    cfg_shift = 1'b0; cfg_update = 1'b0; cfg_sdi = 1'b0;
    b = {1'b1, w[CW-1:1]};
    cfg_shift = 1'b1;
    for (int j = 0; j < CW; j++) begin
      chk("shift_upd_sdo", N'(cfg_sdo), N'(b[j]));
      d = N'($urandom); ce = N'($urandom);
      tick();
      check("shift_out");
    end
    cfg_shift = 1'b0;

    // async priority on channel 2
    d = '0; ce = '1;
    shift_word('0);
    update();
    tick();
    check("async_pre");
    as[2] = 1'b1; #1 model_async(); check("as");
    qv = q; chk("as_q2", N'(qv[2]), N'(1));
    ar[2] = 1'b1; #1 model_async(); check("ar_as");
    qv = q; chk("ar_as_q2", N'(qv[2]), N'(0));
    ar[2] = 1'b0; #1 model_async(); check("ar_drop");
    qv = q; chk("ar_drop_q2", N'(qv[2]), N'(1));
    as[2] = 1'b0; d[2] = 1'b0; ce[2] = 1'b1;
    tick();
    check("async_release");
    qv = q; chk("async_release_q2", N'(qv[2]), N'(0));

    // bypass + invert on channel 1, then hold
    w = '0; w[5:3] = 3'b110;
    shift_word(w);
    update();
    d[1] = 1'b0; #1 check("byp0");
    qv = q; chk("byp0_q1", N'(qv[1]), N'(1));
    d[1] = 1'b1; #1 check("byp1");
    qv = q; chk("byp1_q1", N'(qv[1]), N'(0));
    w[5:3] = 3'b011;
    shift_word(w);
    update();
    qv = exp_q(); held = qv[1];
    for (int i = 0; i < 4; i++) begin
      d = N'($urandom); ce = N'($urandom);
      tick();
      check("hold");
      qv = q; chk("hold_q1", N'(qv[1]), N'(held));
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      gclr_n     = ($urandom_range(0, 39) != 0);
      d          = N'($urandom);
      ce         = N'($urandom);
      ar         = N'($urandom & $urandom & $urandom);
      as         = N'($urandom & $urandom & $urandom);
      cfg_shift  = ($urandom_range(0, 2) != 0);
      cfg_sdi    = 1'($urandom);
      cfg_update = ($urandom_range(0, 5) == 0);
      #1 model_async();
      check("rand_comb");
      tick();
      check("rand_edge");
    end

    // reset in the middle of a shift
    gclr_n = 1'b1; ar = '0; as = '0; cfg_update = 1'b0; d = '1; ce = '0;
    cfg_shift = 1'b1; cfg_sdi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_shift");
    end
    gclr_n = 1'b0; #1 model_async();
    check("mid_reset");
    chk("mid_reset_q", q, '0);
    tick();
    gclr_n = 1'b1; cfg_sdi = 1'b0;
    for (int i = 0; i < CW; i++) begin
      tick();
      check("drain");
      chk("drain_sdo", N'(cfg_sdo), '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
